// File: rtl/ifetch_pc.sv
// PC register and instruction-fetch sequencer: one imem request per instruction,
// captured word held for decode until it is accepted, then the next PC is loaded.
module ifetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_in,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    StIssue,
    StWait,
    StHold
  } state_e;

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic        addr_err_q, addr_err_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q;
    addr_err_d    = addr_err_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      StIssue: begin
        state_d    = StWait;
        wait_cnt_d = '0;
      end
      StWait: begin
        if (imem_valid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = StHold;
        end else begin
          // Timeout only flags the error; a late response is still accepted.
          if (wait_cnt_q != TimeoutCnt) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
          end
          if (wait_cnt_d == TimeoutCnt) begin
            fetch_err_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (instr_valid_q && !stall) begin
          pc_d          = {npc_in[31:2], 2'b00};
          instr_valid_d = 1'b0;
          state_d       = StIssue;
          if (npc_in[1:0] != 2'b00) begin
            addr_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIssue;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIssue;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      addr_err_q    <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      addr_err_q    <= addr_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign imem_req    = (state_q == StIssue);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_ifetch_pc.sv
// Bench for ifetch_pc: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the fetch loop.
module tb_ifetch_pc;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int          Tmo     = 16;

  logic        clk;
  logic        rst;
  logic [31:0] npc_in;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic        addr_err;

  ifetch_pc #(
    .RESET_PC(ResetPc),
    .TIMEOUT (Tmo)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .npc_in     (npc_in),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr      (instr),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: where the current instruction is in its life (requesting, awaiting memory,
  // or delivered to decode) plus architectural PC and the sticky flags.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_requesting;
  logic        m_awaiting;
  logic        m_delivered;
  int          m_waited;
  logic        m_ferr;
  logic        m_aerr;

  // Observation log for the throughput scenario.
  logic        rec;
  int          step_no;
  logic [31:0] req_log[$];
  int          iv_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic s, input logic [31:0] npc,
                              input logic v, input logic [31:0] d);
    if (r) begin
      m_pc = ResetPc; m_instr = '0; m_requesting = 1'b1; m_awaiting = 1'b0;
      m_delivered = 1'b0; m_waited = 0; m_ferr = 1'b0; m_aerr = 1'b0;
    end else if (m_requesting) begin
      m_requesting = 1'b0; m_awaiting = 1'b1; m_waited = 0;
    end else if (m_awaiting) begin
      if (v) begin
        m_instr = d; m_awaiting = 1'b0; m_delivered = 1'b1;
      end else begin
        m_waited++;
        if (m_waited >= Tmo) m_ferr = 1'b1;
      end
    end else if (m_delivered && !s) begin
      m_pc = npc & 32'hFFFF_FFFC;
      if (npc % 4 != 0) m_aerr = 1'b1;
      m_delivered = 1'b0; m_requesting = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("imem_req", {31'd0, imem_req}, {31'd0, m_requesting});
    check("imem_addr", imem_addr, m_pc);
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("instr", instr, m_instr);
    check("instr_valid", {31'd0, instr_valid}, {31'd0, m_delivered});
    check("fetch_err", {31'd0, fetch_err}, {31'd0, m_ferr});
    check("addr_err", {31'd0, addr_err}, {31'd0, m_aerr});
  endtask

  task automatic step(input logic r, input logic s, input logic [31:0] npc,
                      input logic v, input logic [31:0] d);
    rst = r; stall = s; npc_in = npc; imem_valid = v; imem_rdata = d;
    @(posedge clk);
    model_update(r, s, npc, v, d);
    #1;
    step_no++;
    if (rec) begin
      if (imem_req) req_log.push_back(imem_addr);
      if (instr_valid) iv_log.push_back(step_no);
    end
    compare_all();
  endtask

  // Drive until the model says the instruction is delivered; bounded.
  task automatic run_to_hold(input logic [31:0] data);
    int n = 0;
    while (!m_delivered && n < 10) begin
      step(1'b0, 1'b0, 32'h0, m_awaiting, data);
      n++;
    end
    check("run_to_hold_bound", {31'd0, m_delivered}, 32'd1);
  endtask

  initial begin
    logic        r, s, v, slow;
    logic [31:0] npc, d;

    rec = 1'b0; step_no = 0;
    m_pc = '0; m_instr = '0; m_requesting = 1'b0; m_awaiting = 1'b0;
    m_delivered = 1'b0; m_waited = 0; m_ferr = 1'b0; m_aerr = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_iv", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);

    // Zero-wait memory, sequential PC: 3 cycles per instruction
    rec = 1'b1; step_no = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, m_pc + 32'd4, 1'b1, 32'h2008_0005);
    rec = 1'b0;
    check("seq_req_count", req_log.size(), 32'd2);
    if (req_log.size() == 2) begin
      check("seq_req0_addr", req_log[0], 32'h4);
      check("seq_req1_addr", req_log[1], 32'h8);
    end
    check("seq_iv_count", iv_log.size(), 32'd3);
    if (iv_log.size() == 3) begin
      check("seq_iv0_cycle", iv_log[0], 32'd2);
      check("seq_iv1_cycle", iv_log[1], 32'd5);
      check("seq_iv2_cycle", iv_log[2], 32'd8);
    end
    check("seq_pc_plus4", pc_plus4, 32'hC);

    // Stall in hold: everything frozen, spurious imem_valid ignored
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'h40, 1'b1, $urandom);
      check("stall_instr", instr, 32'h2008_0005);
      check("stall_pc", pc, 32'h8);
      check("stall_iv", {31'd0, instr_valid}, 32'd1);
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    step(1'b0, 1'b0, 32'h40, 1'b0, 32'h0);
    check("unstall_pc", pc, 32'h40);
    check("unstall_req", {31'd0, imem_req}, 32'd1);
    check("unstall_addr", imem_addr, 32'h40);

    // Slow memory: 20 wait cycles with TIMEOUT=16
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("tmo_before", {31'd0, fetch_err}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("tmo_at16", {31'd0, fetch_err}, 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001);
    check("late_instr", instr, 32'hCAFE_0001);
    check("late_iv", {31'd0, instr_valid}, 32'd1);
    check("late_ferr", {31'd0, fetch_err}, 32'd1);

    // Misaligned next PC
    step(1'b0, 1'b0, 32'h0000_0102, 1'b0, 32'h0);
    check("mis_pc", pc, 32'h0000_0100);
    check("mis_aerr", {31'd0, addr_err}, 32'd1);

    // Top of address space wraps
    run_to_hold(32'h1111_2222);
    step(1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    run_to_hold(32'h3333_4444);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("wrap_npc0", pc, 32'h0);
    check("sticky_aerr", {31'd0, addr_err}, 32'd1);
    check("sticky_ferr", {31'd0, fetch_err}, 32'd1);

    // Reset collides with a memory response
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    check("rstv_iv", {31'd0, instr_valid}, 32'd0);
    check("rstv_instr", instr, 32'h0);
    check("rstv_pc", pc, ResetPc);
    check("rstv_ferr", {31'd0, fetch_err}, 32'd0);
    check("rstv_aerr", {31'd0, addr_err}, 32'd0);
    check("rstv_req", {31'd0, imem_req}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      slow = ((n / 400) % 3 == 2);
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 2) == 0);
      npc = $urandom;
      if ($urandom_range(0, 7) != 0) npc = npc & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) npc = 32'hFFFF_FFFC;
      v = slow ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1) == 0);
      d = $urandom;
      step(r, s, npc, v, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
